// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave serial datapath.
// Optional feature macro: S2P_PARITY_EN (adds one even-parity bit per frame).
package spi_pkg;

    // Receiver control states: waiting for a frame, or shifting one in.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } s2p_state_e;

    // Bits on the wire per frame for a given data width.
    function automatic int frame_len(input int width);
`ifdef S2P_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    // Bit counter width able to hold 0..frame_len.
    function automatic int cnt_width(input int width);
        return $clog2(frame_len(width) + 1);
    endfunction

    // Values for the default 8-bit frame.
    localparam int FRAME_LEN = frame_len(8);
    localparam int CNT_W     = cnt_width(8);

endpackage

// File: rtl/s2p_out_reg.sv
// Valid/ready output holding register with overrun detection.
// A word offered on 'load' is taken if the register is empty or is being
// drained on the same edge; otherwise it is dropped and 'overrun' pulses.
module s2p_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             din_err,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             err,
    output logic             overrun
);

    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             err_q;
    logic             overrun_q;
    logic             free;

    // Space exists when empty or when the held word is accepted this edge.
    assign free = !valid_q || ready;

    // Load, drop-with-overrun, or drain the holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= load && !free;
            if (load && free) begin
                dout_q  <= din;
                err_q   <= din_err;
                valid_q <= 1'b1;
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/serial_to_parallel_rx.sv
// LSB-first serial-to-parallel receiver for the SPI slave.
// One bit is sampled per clk while en is high; completed words are handed to
// s2p_out_reg one cycle after the last bit.
// Optional feature macro: S2P_PARITY_EN (frame carries a trailing even-parity bit).
module serial_to_parallel_rx
    import spi_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_done,
    output logic             overrun,
    output logic             parity_err
);

    localparam int FRAME_BITS = frame_len(WIDTH);
    localparam int CNT_BITS   = cnt_width(WIDTH);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(FRAME_BITS - 1);

    s2p_state_e        state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic              complete_q, complete_d;
    logic              frame_done_q;
    logic [WIDTH-1:0]  bit_sel;
    logic              frame_err;

    // One-hot decode of the bit position the next sample lands in.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_sel
            assign bit_sel[gi] = (cnt_q == CNT_BITS'(gi));
        end
    endgenerate

`ifdef S2P_PARITY_EN
    logic par_bit_q, par_bit_d;
    localparam logic [CNT_BITS-1:0] PAR_CNT = CNT_BITS'(WIDTH);
`endif

    // Next-state: counter, shift register and completion flag.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        complete_d = 1'b0;
`ifdef S2P_PARITY_EN
        par_bit_d  = par_bit_q;
`endif
        if (!en) begin
            // Dropping en abandons any partial frame.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (bit_sel[i]) begin
                    sr_d[i] = serial_in;
                end
            end
`ifdef S2P_PARITY_EN
            if (cnt_q == PAR_CNT) begin
                par_bit_d = serial_in;
            end
`endif
            case (state_q)
                IDLE: begin
                    cnt_d   = CNT_BITS'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d      = '0;
                        complete_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State register for the shifter and completion pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            complete_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            complete_q   <= complete_d;
            frame_done_q <= complete_q;
        end
    end

`ifdef S2P_PARITY_EN
    // Trailing parity bit, held until the word is handed over.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit_q <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
        end
    end

    assign frame_err = (^sr_q) ^ par_bit_q;
`else
    assign frame_err = 1'b0;
`endif

    s2p_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (complete_q),
        .din     (sr_q),
        .din_err (frame_err),
        .ready   (dout_ready),
        .dout    (dout),
        .valid   (dout_valid),
        .err     (parity_err),
        .overrun (overrun)
    );

    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench for serial_to_parallel_rx (WIDTH=8).
// Honours S2P_PARITY_EN when the build defines it.
module tb_serial_to_parallel_rx;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             serial_in;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             frame_done;
    logic             overrun;
    logic             parity_err;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_cnt   = 0;
    int ovr_cnt  = 0;

    typedef struct {
        logic             en;
        logic             sin;
        logic             rdy;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_dout;
        logic             exp_fd;
    } vec_t;

    vec_t vecs[$];

    serial_to_parallel_rx #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .serial_in  (serial_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_done (frame_done),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (overrun)    ovr_cnt <= ovr_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("check %s: got 0x%0h ok", name, act);
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sends one full frame with en held high; en is left high afterwards.
    task automatic send_frame(input logic [WIDTH-1:0] word, input logic par);
        for (int i = 0; i < WIDTH; i++) begin
            en        = 1'b1;
            serial_in = word[i];
            tick();
        end
`ifdef S2P_PARITY_EN
        en        = 1'b1;
        serial_in = par;
        tick();
`else
        if (par === 1'bx) $display("note: parity bit undefined");
`endif
    endtask

    function automatic vec_t mk(input logic e, input logic s, input logic r,
                                input logic v, input logic [WIDTH-1:0] d, input logic f);
        vec_t t;
        t.en = e; t.sin = s; t.rdy = r;
        t.exp_valid = v; t.exp_dout = d; t.exp_fd = f;
        return t;
    endfunction

    initial begin
        logic [WIDTH-1:0] w;
        int fd0;
        int ov0;

        rst        = 1'b1;
        en         = 1'b0;
        serial_in  = 1'b0;
        dout_ready = 1'b0;
        tick();
        tick();
        chk("reset valid", {31'd0, dout_valid}, 32'd0);
        chk("reset dout", {24'd0, dout}, 32'd0);
        chk("reset frame_done", {31'd0, frame_done}, 32'd0);
        chk("reset overrun", {31'd0, overrun}, 32'd0);
        chk("reset parity_err", {31'd0, parity_err}, 32'd0);
        rst = 1'b0;

        // Basic frame 0x4D sent as bits 1,0,1,1,0,0,1,0 (first bit = bit 0).
        w = 8'h4D;
        for (int i = 0; i < WIDTH; i++) vecs.push_back(mk(1'b1, w[i], 1'b0, 1'b0, 8'h00, 1'b0));
`ifdef S2P_PARITY_EN
        vecs.push_back(mk(1'b1, ^w, 1'b0, 1'b0, 8'h00, 1'b0));
`endif
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h4D, 1'b1)); // completion visible
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0)); // accepted
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0)); // ready ignored when empty

        for (int k = 0; k < vecs.size(); k++) begin
            en         = vecs[k].en;
            serial_in  = vecs[k].sin;
            dout_ready = vecs[k].rdy;
            tick();
            chk($sformatf("vec%0d valid", k), {31'd0, dout_valid}, {31'd0, vecs[k].exp_valid});
            chk($sformatf("vec%0d frame_done", k), {31'd0, frame_done}, {31'd0, vecs[k].exp_fd});
            chk($sformatf("vec%0d overrun", k), {31'd0, overrun}, 32'd0);
            if (vecs[k].exp_valid)
                chk($sformatf("vec%0d dout", k), {24'd0, dout}, {24'd0, vecs[k].exp_dout});
        end
        dout_ready = 1'b0;

        // Abort: 5 bits, en low one cycle, then a full 0xA5 frame.
        fd0 = fd_cnt;
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; serial_in = 1'b1; tick();
        end
        en = 1'b0; tick();
        send_frame(8'hA5, ^8'hA5);
        chk("abort no early valid", {31'd0, dout_valid}, 32'd0);
        en = 1'b0; tick();
        chk("abort valid", {31'd0, dout_valid}, 32'd1);
        chk("abort dout", {24'd0, dout}, 32'h000000A5);
        tick();
        chk("abort frame_done count", fd_cnt - fd0, 32'd1);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        chk("abort drained", {31'd0, dout_valid}, 32'd0);

        // Back-to-back 0x3C, 0xC3 with consumer stalled: second word dropped.
        fd0 = fd_cnt; ov0 = ovr_cnt;
        send_frame(8'h3C, ^8'h3C);
        send_frame(8'hC3, ^8'hC3);
        en = 1'b0; tick();
        chk("stall overrun pulse", {31'd0, overrun}, 32'd1);
        chk("stall valid", {31'd0, dout_valid}, 32'd1);
        chk("stall dout held", {24'd0, dout}, 32'h0000003C);
        tick();
        chk("stall overrun ends", {31'd0, overrun}, 32'd0);
        chk("stall overrun count", ovr_cnt - ov0, 32'd1);
        chk("stall frame_done count", fd_cnt - fd0, 32'd2);
        chk("stall dout still", {24'd0, dout}, 32'h0000003C);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        chk("stall drained", {31'd0, dout_valid}, 32'd0);

        // Accept exactly on the completion edge of the second frame.
        ov0 = ovr_cnt;
        send_frame(8'h3C, ^8'h3C);
        send_frame(8'hC3, ^8'hC3);
        chk("collide first held", {24'd0, dout}, 32'h0000003C);
        chk("collide first valid", {31'd0, dout_valid}, 32'd1);
        en = 1'b0; dout_ready = 1'b1; tick();
        dout_ready = 1'b0;
        chk("collide valid kept", {31'd0, dout_valid}, 32'd1);
        chk("collide dout new", {24'd0, dout}, 32'h000000C3);
        chk("collide no overrun", {31'd0, overrun}, 32'd0);
        tick();
        chk("collide valid after", {31'd0, dout_valid}, 32'd1);
        chk("collide overrun count", ovr_cnt - ov0, 32'd0);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        chk("collide drained", {31'd0, dout_valid}, 32'd0);

        // Reset mid-frame while a word is held.
        send_frame(8'h5A, ^8'h5A);
        en = 1'b0; tick();
        chk("pre-reset valid", {31'd0, dout_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; serial_in = 1'b1; tick();
        end
        rst = 1'b1; en = 1'b1; serial_in = 1'b1; tick();
        chk("midrst valid", {31'd0, dout_valid}, 32'd0);
        chk("midrst dout", {24'd0, dout}, 32'd0);
        chk("midrst frame_done", {31'd0, frame_done}, 32'd0);
        chk("midrst overrun", {31'd0, overrun}, 32'd0);
        chk("midrst parity_err", {31'd0, parity_err}, 32'd0);
        rst = 1'b0;
        send_frame(8'hFF, ^8'hFF);
        en = 1'b0; tick();
        chk("post-reset valid", {31'd0, dout_valid}, 32'd1);
        chk("post-reset dout", {24'd0, dout}, 32'h000000FF);
        chk("post-reset frame_done", {31'd0, frame_done}, 32'd1);
        chk("post-reset parity_err", {31'd0, parity_err}, 32'd0);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;

`ifdef S2P_PARITY_EN
        // 0x07 has three ones: parity bit 1 is correct, 0 is an error.
        send_frame(8'h07, 1'b1);
        en = 1'b0; tick();
        chk("parity good dout", {24'd0, dout}, 32'h00000007);
        chk("parity good err", {31'd0, parity_err}, 32'd0);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        send_frame(8'h07, 1'b0);
        en = 1'b0; tick();
        chk("parity bad dout", {24'd0, dout}, 32'h00000007);
        chk("parity bad err", {31'd0, parity_err}, 32'd1);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
